// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, data word and arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } arb_state_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of data grants issued while an instruction fetch waits.
module arb_streak_counter
    import cpu_types_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [STREAK_W-1:0] cnt;

    assign at_max = (cnt >= STREAK_W'(MAX));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data access,
// with data priority bounded by a starvation streak limit.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arb_state_t state;
    arb_state_t next_state;
    arb_state_t cur;
    logic       dreq;
    logic       acc;
    logic       s_inc;
    logic       s_clr;
    logic       at_max;

    assign dreq = dREN | dWEN;
    assign acc  = (ramstate == ACCESS);
    // Reset forces the idle view of the outputs even mid-grant.
    assign cur  = RST ? IDLE : state;

    arb_streak_counter #(
        .MAX(DSTREAK_MAX)
    ) u_streak (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (s_clr),
        .inc   (s_inc),
        .at_max(at_max)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = iREN;
        dwait      = dreq;
        iload      = '0;
        dload      = '0;
        s_inc      = 1'b0;
        s_clr      = 1'b0;
        unique case (cur)
            IDLE: begin
                if (!iREN) begin
                    s_clr = 1'b1;
                end
                if (dreq && !(iREN && at_max)) begin
                    next_state = DGRANT;
                    s_inc      = iREN;
                end else if (iREN) begin
                    next_state = IGRANT;
                    s_clr      = 1'b1;
                end
            end
            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (acc) begin
                    dwait      = 1'b0;
                    dload      = ramload;
                    next_state = IDLE;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (acc) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic scored against a RAM model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int DMAX = 4;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    mem_arbiter #(
        .DSTREAK_MAX(DMAX)
    ) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate)
    );

    int    n_chk = 0;
    int    n_pass = 0;
    logic  mon_en = 0;
    logic  ram_init = 0;
    logic  i_done;
    logic  d_done;
    word_t ram [16];
    word_t shadow [8];
    word_t iq [$];
    word_t dq [$];
    int    igap, ia, iwt;
    int    dgap, da, dwt, dop;
    int    rs;

    initial CLK = 0;
    always #5 CLK = ~CLK;

    function automatic word_t init_val(input int i);
        return 32'h1000_0000 + word_t'(i) * 32'h0001_0111;
    endfunction

    // RAM model: combinational read, write on an ACCESS edge.
    assign ramload = ram[ramaddr[5:2]];

    always @(posedge CLK) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
        end else if (ramWEN && ramstate == ACCESS) begin
            ram[ramaddr[5:2]] <= ramstore;
        end
    end

    task automatic check(input string name, input word_t got,
                         input word_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (iREN && !iwait) begin
                if (iq.size() == 0) check("iq_underflow", 1, 0);
                else check("rnd_iload", iload, iq.pop_front());
            end
            if (dREN && !dWEN && !dwait) begin
                if (dq.size() == 0) check("dq_underflow", 1, 0);
                else check("rnd_dload", dload, dq.pop_front());
            end
            if (!iREN) check("rnd_iwait_low", 32'(iwait), 0);
            if (!dREN && !dWEN) check("rnd_dwait_low", 32'(dwait), 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
        daddr = 0; dstore = 0; ramstate = FREE; ram_init = 1;
        tick();
        iREN = 1; dREN = 1;
        @(negedge CLK);
        check("rst_ramREN", 32'(ramREN), 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_iwait", 32'(iwait), 1);
        check("rst_dwait", 32'(dwait), 1);
        check("rst_iload", iload, 0);
        tick();
        iREN = 0; dREN = 0; RST = 0; ram_init = 0;
        tick();

        // data read completing after two BUSY cycles
        dREN = 1; daddr = 32'h40; ramstate = BUSY;
        @(negedge CLK);
        check("d31_idle_dwait", 32'(dwait), 1);
        check("d31_idle_ramREN", 32'(ramREN), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            ramstate = (k == 2) ? ACCESS : BUSY;
            @(negedge CLK);
            check("d31_ramREN", 32'(ramREN), 1);
            check("d31_dwait", 32'(dwait), (k == 2) ? 1'b0 : 1'b1);
            check("d31_ramaddr", ramaddr, 32'h40);
            if (k == 2) check("d31_dload", dload, init_val(0));
        end
        tick();
        dREN = 0;
        @(negedge CLK);
        check("d31_after", 32'(ramREN), 0);
        tick();

        // read+write together is a write
        dREN = 1; dWEN = 1; daddr = 32'h60; dstore = 32'hDEADBEEF;
        ramstate = ACCESS;
        tick();
        @(negedge CLK);
        check("d33_ramWEN", 32'(ramWEN), 1);
        check("d33_ramREN", 32'(ramREN), 0);
        check("d33_ramstore", ramstore, 32'hDEADBEEF);
        tick();
        dREN = 0; dWEN = 0;
        @(negedge CLK);
        check("d33_ram", ram[8], 32'hDEADBEEF);
        tick();

        // streak limit: four data grants then the waiting fetch
        iREN = 1; iaddr = 32'h8; dWEN = 1; daddr = 32'h80;
        dstore = 32'h1234; ramstate = ACCESS;
        for (int g = 0; g < 5; g++) begin
            @(negedge CLK);
            check("d32_gap", 32'(ramREN | ramWEN), 0);
            if (g == 4) check("d32_at_max", 32'(u_dut.u_streak.cnt), DMAX);
            tick();
            @(negedge CLK);
            check("d32_dgrant", 32'(ramWEN), (g < 4) ? 1'b1 : 1'b0);
            check("d32_igrant", 32'(ramREN), (g == 4) ? 1'b1 : 1'b0);
            tick();
        end
        iREN = 0; dWEN = 0;
        @(negedge CLK);
        check("d32_cnt_clr", 32'(u_dut.u_streak.cnt), 0);
        tick();

        // fetch retried through ERROR
        iREN = 1; iaddr = 32'h14; ramstate = ERROR;
        tick();
        for (int k = 0; k < 4; k++) begin
            ramstate = (k < 3) ? ERROR : ACCESS;
            @(negedge CLK);
            check("d34_iwait", 32'(iwait), (k < 3) ? 1'b1 : 1'b0);
            check("d34_ramaddr", ramaddr, 32'h14);
            if (k == 3) check("d34_iload", iload, init_val(5));
            tick();
        end
        iREN = 0;
        tick();

        // reset during a data grant
        dREN = 1; daddr = 32'h48; ramstate = BUSY;
        tick();
        @(negedge CLK);
        check("d35_grant", 32'(ramREN), 1);
        tick();
        RST = 1;
        @(negedge CLK);
        check("d35_rst_ramREN", 32'(ramREN), 0);
        check("d35_rst_dwait", 32'(dwait), 1);
        tick();
        RST = 0;
        @(negedge CLK);
        check("d35_state", 32'(u_dut.state), 32'(IDLE));
        check("d35_cnt", 32'(u_dut.u_streak.cnt), 0);
        check("d35_idle_ramREN", 32'(ramREN), 0);
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        check("d35_regrant", 32'(ramREN), 1);
        check("d35_done", 32'(dwait), 0);
        tick();
        dREN = 0;
        tick();

        // data withdrawn mid-grant, pending fetch served next
        dREN = 1; iREN = 1; daddr = 32'h4C; iaddr = 32'h10;
        ramstate = BUSY;
        tick();
        @(negedge CLK);
        check("d36_daddr", ramaddr, 32'h4C);
        check("d36_iwait", 32'(iwait), 1);
        tick();
        dREN = 0;
        @(negedge CLK);
        check("d36_drop", 32'(ramREN), 0);
        check("d36_dwait", 32'(dwait), 0);
        tick();
        @(negedge CLK);
        check("d36_idle", 32'(ramREN), 0);
        check("d36_idle_iwait", 32'(iwait), 1);
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        check("d36_iaddr", ramaddr, 32'h10);
        check("d36_iREN", 32'(ramREN), 1);
        check("d36_iload", iload, init_val(4));
        tick();
        iREN = 0;

        // randomized traffic
        RST = 1; ram_init = 1;
        tick();
        RST = 0; ram_init = 0;
        for (int i = 0; i < 8; i++) shadow[i] = init_val(8 + i);
        i_done = 0; d_done = 0; mon_en = 1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    igap = $urandom_range(0, 2);
                    repeat (igap) tick();
                    ia = $urandom_range(0, 7);
                    iaddr = word_t'(ia) << 2;
                    iREN = 1;
                    iq.push_back(init_val(ia));
                    iwt = 0;
                    do begin
                        @(negedge CLK);
                        iwt++;
                    end while (iwait && iwt < 300);
                    if (iwait) check("i_timeout", 32'(iwait), 0);
                    tick();
                    iREN = 0;
                end
                i_done = 1;
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    dgap = $urandom_range(0, 2);
                    repeat (dgap) tick();
                    da = $urandom_range(0, 7);
                    daddr = word_t'(8 + da) << 2;
                    dop = $urandom_range(0, 1);
                    if (dop == 1) begin
                        dWEN = 1;
                        dREN = 1'($urandom_range(0, 1));
                        dstore = $urandom;
                        shadow[da] = dstore;
                    end else begin
                        dREN = 1;
                        dWEN = 0;
                        dq.push_back(shadow[da]);
                    end
                    dwt = 0;
                    do begin
                        @(negedge CLK);
                        dwt++;
                    end while (dwait && dwt < 300);
                    if (dwait) check("d_timeout", 32'(dwait), 0);
                    tick();
                    dREN = 0; dWEN = 0;
                end
                d_done = 1;
            end
            begin
                while (!(i_done && d_done)) begin
                    tick();
                    rs = $urandom_range(0, 7);
                    ramstate = (rs < 4) ? ACCESS :
                               (rs < 6) ? BUSY :
                               (rs < 7) ? ERROR : FREE;
                end
            end
        join
        mon_en = 0;
        tick();
        check("iq_drain", iq.size(), 0);
        check("dq_drain", dq.size(), 0);
        for (int i = 0; i < 8; i++) check("ram_final", ram[8 + i], shadow[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
